// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one 256x8 synchronous memory among three requesters: instruction
// fetch (F), data load/store (D) and a host/debug loader (H). Only one access
// is in flight at a time. Each access walks IDLE -> ISSUE -> RESP. From RESP
// the next access can be issued back-to-back, so sustained throughput is one
// access every two cycles.
//
// Arbitration
//   Default build (MEM_ARB_RR_EN undefined):
//     fixed priority D > F > H, plus an aging counter. When H has waited
//     AGE_MAX cycles it is promoted to top priority, so it cannot starve.
//   MEM_ARB_RR_EN defined:
//     round-robin over F, D, H. The search starts one past the last winner.
//
// Ports
//   clk_i, rst_i                clock, synchronous active-high reset
//   f_req_i, f_addr_i           fetch read request, held until f_ack_o
//   d_req_i, d_we_i, d_addr_i,  data load/store request, held until d_ack_o
//   d_wdata_i
//   h_req_i, h_we_i, h_addr_i,  host read/write request, held until h_ack_o
//   h_wdata_i
//   f_ack_o, d_ack_o, h_ack_o   one-cycle completion pulses, at most one high
//   rdata_o                     pass-through of mem_rdata_i, valid on read acks
//   mem_en_o, mem_we_o,         registered memory strobes, address and data
//   mem_addr_o, mem_wdata_o
//   mem_rdata_i                 memory read data, valid the cycle after mem_en_o
//   grant_id_o                  current/last owner: 0=F 1=D 2=H
//   busy_o                      high whenever the FSM is not IDLE
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int AGE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  input  logic              h_req_i,
  input  logic              h_we_i,
  input  logic [ADDR_W-1:0] h_addr_i,
  input  logic [DATA_W-1:0] h_wdata_i,
  output logic              h_ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        grant_id_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [1:0] ID_F = 2'd0;
  localparam logic [1:0] ID_D = 2'd1;
  localparam logic [1:0] ID_H = 2'd2;

  state_t              state_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [1:0]          grant_q;

  logic [3:0]          req_vec;   // {pad, H, D, F}
  logic                arb_valid;
  logic [1:0]          arb_id;

`ifdef MEM_ARB_RR_EN
  logic [1:0]          rr_last_q;
  logic [1:0]          rr_last_d;
`else
  localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);
  logic [3:0]          age_q;
  logic [3:0]          age_d;
`endif

  // Requests that may compete this cycle. ISSUE never arbitrates.
  // In RESP the port being acked is masked, so it cannot win again
  // while its own ack is still on the wire.
  always_comb begin
    req_vec = {1'b0, h_req_i, d_req_i, f_req_i};
    if (state_q == ST_ISSUE) begin
      req_vec = 4'b0000;
    end else if (state_q == ST_RESP) begin
      req_vec[grant_q] = 1'b0;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin. The three search orders are rotations of F,D,H,
  // starting just after the last winner.
  always_comb begin
    logic [1:0] o0, o1, o2;
    case (rr_last_q)
      ID_F:    begin o0 = ID_D; o1 = ID_H; o2 = ID_F; end
      ID_D:    begin o0 = ID_H; o1 = ID_F; o2 = ID_D; end
      default: begin o0 = ID_F; o1 = ID_D; o2 = ID_H; end
    endcase
    arb_valid = 1'b1;
    arb_id    = o0;
    if (req_vec[o0])      arb_id = o0;
    else if (req_vec[o1]) arb_id = o1;
    else if (req_vec[o2]) arb_id = o2;
    else                  arb_valid = 1'b0;
    rr_last_d = arb_valid ? arb_id : rr_last_q;
  end
`else
  // Fixed priority D > F > H, unless H has aged out.
  // The age counts every cycle H waits, including ISSUE cycles where
  // nobody can win. It clears when H wins or drops its request.
  always_comb begin
    arb_valid = 1'b1;
    arb_id    = ID_D;
    if (req_vec[ID_H] && (age_q >= AGE_LIM)) arb_id = ID_H;
    else if (req_vec[ID_D])                  arb_id = ID_D;
    else if (req_vec[ID_F])                  arb_id = ID_F;
    else if (req_vec[ID_H])                  arb_id = ID_H;
    else                                     arb_valid = 1'b0;

    if (!h_req_i || (arb_valid && arb_id == ID_H)) begin
      age_d = 4'd0;
    end else if (age_q < AGE_LIM) begin
      age_d = age_q + 4'd1;
    end else begin
      age_d = age_q;
    end
  end
`endif

  // Main FSM. The memory strobes and grant id are registered here.
  // A winner in IDLE or RESP loads its command and moves to ISSUE.
  // The ISSUE cycle always drops the strobe and moves to RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_q     <= ID_F;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= ID_H;
`else
      age_q       <= 4'd0;
`endif
    end else begin
`ifdef MEM_ARB_RR_EN
      rr_last_q <= rr_last_d;
`else
      age_q     <= age_d;
`endif
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (arb_valid) begin
            state_q  <= ST_ISSUE;
            mem_en_q <= 1'b1;
            grant_q  <= arb_id;
            case (arb_id)
              ID_D: begin
                mem_we_q    <= d_we_i;
                mem_addr_q  <= d_addr_i;
                mem_wdata_q <= d_wdata_i;
              end
              ID_H: begin
                mem_we_q    <= h_we_i;
                mem_addr_q  <= h_addr_i;
                mem_wdata_q <= h_wdata_i;
              end
              default: begin
                mem_we_q   <= 1'b0;
                mem_addr_q <= f_addr_i;
              end
            endcase
          end else begin
            state_q  <= ST_IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_q  <= ST_RESP;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  // Acks decode from the state alone. Only one port owns RESP,
  // so two acks can never be high together.
  assign f_ack_o = (state_q == ST_RESP) && (grant_q == ID_F);
  assign d_ack_o = (state_q == ST_RESP) && (grant_q == ID_D);
  assign h_ack_o = (state_q == ST_RESP) && (grant_q == ID_H);

  assign rdata_o     = mem_rdata_i;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// -------------------
// Directed bench for mem_port_arbiter. A behavioural 256x8 synchronous RAM
// sits on the memory side. Each step drives requests just after a rising
// edge and checks outputs one time unit after the next edge.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       fReq, dReq, dWe, hReq, hWe;
  logic [7:0] fAddr, dAddr, dWdata, hAddr, hWdata;
  logic       fAck, dAck, hAck;
  logic [7:0] rdata;
  logic       memEn, memWe;
  logic [7:0] memAddr, memWdata;
  logic [7:0] memRdata = 8'h00;
  logic [1:0] grantId;
  logic       busy;

  logic [7:0] ram [256];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .AGE_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .f_req_i(fReq), .f_addr_i(fAddr), .f_ack_o(fAck),
    .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata), .d_ack_o(dAck),
    .h_req_i(hReq), .h_we_i(hWe), .h_addr_i(hAddr), .h_wdata_i(hWdata), .h_ack_o(hAck),
    .rdata_o(rdata),
    .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata),
    .grant_id_o(grantId), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM model.
  always @(posedge clk) begin
    if (memEn) begin
      if (memWe) ram[memAddr] <= memWdata;
      memRdata <= ram[memAddr];
    end
  end

  // Safety net, in case a step ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic fR, input logic [7:0] fA,
    input logic dR, input logic dW, input logic [7:0] dA, input logic [7:0] dD,
    input logic hR, input logic hW, input logic [7:0] hA, input logic [7:0] hD);
    fReq = fR; fAddr = fA;
    dReq = dR; dWe = dW; dAddr = dA; dWdata = dD;
    hReq = hR; hWe = hW; hAddr = hA; hWdata = hD;
  endtask

  initial begin
    logic [2:0] ackExp [1:8];
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h10] = 8'h44;

    // Reset state.
    rst = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick(); tick();
    checkOutput("rst_en",    32'(memEn),    32'd0);
    checkOutput("rst_we",    32'(memWe),    32'd0);
    checkOutput("rst_addr",  32'(memAddr),  32'd0);
    checkOutput("rst_wdata", 32'(memWdata), 32'd0);
    checkOutput("rst_grant", 32'(grantId),  32'd0);
    checkOutput("rst_busy",  32'(busy),     32'd0);
    checkOutput("rst_acks",  32'({hAck, dAck, fAck}), 32'd0);
    rst = 1'b0;

    // 1: fetch 0x10 -> strobe next cycle, ack and data the cycle after.
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("t1_en",    32'(memEn),   32'd1);
    checkOutput("t1_addr",  32'(memAddr), 32'h10);
    checkOutput("t1_we",    32'(memWe),   32'd0);
    checkOutput("t1_busy",  32'(busy),    32'd1);
    checkOutput("t1_noack", 32'(fAck),    32'd0);
    tick();
    checkOutput("t1_ack",   32'(fAck),    32'd1);
    checkOutput("t1_rdata", 32'(rdata),   32'h44);
    checkOutput("t1_en0",   32'(memEn),   32'd0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("t1_idle",  32'(busy),    32'd0);

    // 2: store 0x06 to 0xFF, then fetch 0xFF back-to-back from RESP.
    applyStimulus(0, 8'h00, 1, 1, 8'hFF, 8'h06, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("t2_grant", 32'(grantId),  32'd1);
    checkOutput("t2_we",    32'(memWe),    32'd1);
    checkOutput("t2_addr",  32'(memAddr),  32'hFF);
    checkOutput("t2_wdata", 32'(memWdata), 32'h06);
    tick();
    checkOutput("t2_dack",  32'({hAck, dAck, fAck}), 32'b010);
    applyStimulus(1, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("t2_b2b_en",  32'(memEn),   32'd1);
    checkOutput("t2_b2b_gnt", 32'(grantId), 32'd0);
    tick();
    checkOutput("t2_fack",  32'({hAck, dAck, fAck}), 32'b001);
    checkOutput("t2_rdata", 32'(rdata), 32'h06);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();

    // Host write 0xA5 to 0x00. The follow-up read, raised during the
    // write's ack, must wait for IDLE because the acked port is masked.
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 8'hA5);
    tick();
    checkOutput("th_grant", 32'(grantId), 32'd2);
    checkOutput("th_we",    32'(memWe),   32'd1);
    tick();
    checkOutput("th_wack",  32'({hAck, dAck, fAck}), 32'b100);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00);
    tick();
    checkOutput("th_mask_idle", 32'(busy), 32'd0);
    tick();
    checkOutput("th_rd_en", 32'(memEn), 32'd1);
    tick();
    checkOutput("th_rack",  32'({hAck, dAck, fAck}), 32'b100);
    checkOutput("th_rdata", 32'(rdata), 32'hA5);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();

    // Fetch request dropped after issue: the ack still pulses.
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("tv_ack",   32'(fAck),  32'd1);
    checkOutput("tv_rdata", 32'(rdata), 32'h44);
    tick();

`ifndef MEM_ARB_RR_EN
    // 3: F and D together -> D first, then F back-to-back.
    applyStimulus(1, 8'h10, 1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("t3_grant_d", 32'(grantId), 32'd1);
    checkOutput("t3_addr_d",  32'(memAddr), 32'hFF);
    tick();
    checkOutput("t3_dack",  32'({hAck, dAck, fAck}), 32'b010);
    checkOutput("t3_drd",   32'(rdata), 32'h06);
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("t3_grant_f", 32'(grantId), 32'd0);
    tick();
    checkOutput("t3_fack",  32'({hAck, dAck, fAck}), 32'b001);
    checkOutput("t3_frd",   32'(rdata), 32'h44);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();

    // 4: D, F, H all held. H ages out after D and F and is acked in cycle 6.
    ackExp[1] = 3'b000; ackExp[2] = 3'b010; ackExp[3] = 3'b000;
    ackExp[4] = 3'b001; ackExp[5] = 3'b000; ackExp[6] = 3'b100;
    applyStimulus(1, 8'h10, 1, 0, 8'hFF, 8'h00, 1, 0, 8'h00, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      tick();
      checkOutput($sformatf("t4_acks_c%0d", c), 32'({hAck, dAck, fAck}), 32'(ackExp[c]));
    end
    checkOutput("t4_hrdata", 32'(rdata), 32'hA5);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
`endif

    // 5: reset during ISSUE of a D write. The RAM commits it, but no ack follows.
    applyStimulus(0, 8'h00, 1, 1, 8'h20, 8'h5A, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("t5_issue", 32'(memEn), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("t5_busy", 32'(busy),  32'd0);
    checkOutput("t5_en",   32'(memEn), 32'd0);
    checkOutput("t5_dack", 32'(dAck),  32'd0);
    tick();
    checkOutput("t5_dack2", 32'(dAck), 32'd0);
    applyStimulus(1, 8'h20, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick(); tick();
    checkOutput("t5_fack",  32'(fAck),  32'd1);
    checkOutput("t5_rdata", 32'(rdata), 32'h5A);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();

`ifdef MEM_ARB_RR_EN
    // 6: round-robin with all three held -> F, D, H, F.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ackExp[1] = 3'b000; ackExp[2] = 3'b001; ackExp[3] = 3'b000; ackExp[4] = 3'b010;
    ackExp[5] = 3'b000; ackExp[6] = 3'b100; ackExp[7] = 3'b000; ackExp[8] = 3'b001;
    applyStimulus(1, 8'h10, 1, 0, 8'hFF, 8'h00, 1, 0, 8'h00, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      tick();
      checkOutput($sformatf("t6_acks_c%0d", c), 32'({hAck, dAck, fAck}), 32'(ackExp[c]));
      if (c == 1) checkOutput("t6_gnt_c1", 32'(grantId), 32'd0);
      if (c == 3) checkOutput("t6_gnt_c3", 32'(grantId), 32'd1);
      if (c == 5) checkOutput("t6_gnt_c5", 32'(grantId), 32'd2);
      if (c == 7) checkOutput("t6_gnt_c7", 32'(grantId), 32'd0);
    end
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
